// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Control FSM for the multi-cycle MIPS core. Sequences the shared ALU,
//   register file, PC and unified memory across FETCH / DECODE / EXEC /
//   MEM_RD / MEM_WR / WB. It translates the IR opcode/funct into ALU control
//   codes, stalls on the memory handshake, and counts retired instructions.
//
// Ports
//   clk, reset     single clock; synchronous active-high reset
//   opcode, funct  IR fields (stable from DECODE onward)
//   alu_zero       ALU zero flag, used by BEQ/BNE
//   alu_overflow   ALU overflow flag, latched by ADD/SUB/ADDI in EXEC
//   mem_ready      memory completes the current access this cycle
//   pc_we/pc_src   PC write enable and source select
//   ir_we          IR load enable
//   mem_addr_sel   memory address source (0=PC, 1=ALU result register)
//   mem_we/mem_re  memory write strobe / read request
//   reg_we/reg_dst/wb_src  register file write controls
//   alu_src_b      ALU B operand select
//   alu_opcode/alu_funct   ALU control code
//   state          current FSM state (debug)
//   instr_done     pulse on the last cycle of each instruction
//   ovf_err        pulse when an overflowing writeback is suppressed
//   illegal        sticky flag for an undecodable instruction
//   retired        count of instr_done pulses (wraps)
// ---------------------------------------------------------------------------
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             ir_we,
   output logic             mem_addr_sel,
   output logic             mem_we,
   output logic             mem_re,
   output logic             reg_we,
   output logic [1:0]       reg_dst,
   output logic [1:0]       wb_src,
   output logic [1:0]       alu_src_b,
   output logic [5:0]       alu_opcode,
   output logic [5:0]       alu_funct,
   output logic [2:0]       state,
   output logic             instr_done,
   output logic             ovf_err,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM_RD = 3'd3,
      MEM_WR = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd7
   } stateT;

   typedef enum logic [3:0] {
      OP_LW, OP_SW, OP_J, OP_JAL, OP_JR, OP_BEQ, OP_BNE,
      OP_XORI, OP_ADDI, OP_ADD, OP_SUB, OP_SLT, OP_BAD
   } instrT;

   stateT curState;
   instrT instr;
   logic  ovfLatch;

   assign state = curState;

   // Instruction class from the IR fields; only meaningful from DECODE on.
   always_comb begin
      instr = OP_BAD;
      case (opcode)
         6'b000000: begin
            case (funct)
               6'b001000: instr = OP_JR;
               6'b100000: instr = OP_ADD;
               6'b100010: instr = OP_SUB;
               6'b101010: instr = OP_SLT;
               default:   instr = OP_BAD;
            endcase
         end
         6'b100011: instr = OP_LW;
         6'b101011: instr = OP_SW;
         6'b000010: instr = OP_J;
         6'b000011: instr = OP_JAL;
         6'b000100: instr = OP_BEQ;
         6'b000101: instr = OP_BNE;
         6'b001110: instr = OP_XORI;
         6'b001000: instr = OP_ADDI;
         default:   instr = OP_BAD;
      endcase
   end

   // Control outputs depend on the current state and on same-cycle inputs
   // (mem_ready, alu_zero), so they are decoded combinationally. Reset
   // forces every enable and select to zero regardless of state.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      pc_we        = 1'b0;
      pc_src       = 2'd0;
      ir_we        = 1'b0;
      mem_addr_sel = 1'b0;
      mem_we       = 1'b0;
      mem_re       = 1'b0;
      reg_we       = 1'b0;
      reg_dst      = 2'd0;
      wb_src       = 2'd0;
      alu_src_b    = 2'd0;
      alu_opcode   = 6'b001000;
      alu_funct    = 6'b100000;
      instr_done   = 1'b0;
      ovf_err      = 1'b0;
      if (!reset) begin
         case (curState)
            FETCH: begin
               mem_re = 1'b1;
               if (mem_ready) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
               end
            end
            DECODE: begin
               case (instr)
                  OP_J: begin
                     pc_we      = 1'b1;
                     pc_src     = 2'd2;
                     instr_done = 1'b1;
                  end
                  OP_JAL: begin
                     pc_we      = 1'b1;
                     pc_src     = 2'd2;
                     reg_we     = 1'b1;
                     reg_dst    = 2'd2;
                     wb_src     = 2'd2;
                     instr_done = 1'b1;
                  end
                  OP_JR: begin
                     pc_we      = 1'b1;
                     pc_src     = 2'd3;
                     instr_done = 1'b1;
                  end
                  default: ;
               endcase
            end
            EXEC: begin
               case (instr)
                  OP_LW, OP_SW, OP_ADDI: alu_src_b = 2'd1;
                  OP_XORI: begin
                     alu_opcode = 6'b001110;
                     alu_src_b  = 2'd2;
                  end
                  OP_ADD, OP_SUB, OP_SLT: begin
                     alu_opcode = 6'b000000;
                     alu_funct  = funct;
                  end
                  OP_BEQ: begin
                     alu_opcode = opcode;
                     pc_we      = alu_zero;
                     pc_src     = 2'd1;
                     instr_done = 1'b1;
                  end
                  OP_BNE: begin
                     alu_opcode = opcode;
                     pc_we      = ~alu_zero;
                     pc_src     = 2'd1;
                     instr_done = 1'b1;
                  end
                  default: ;
               endcase
            end
            MEM_RD: begin
               mem_re       = 1'b1;
               mem_addr_sel = 1'b1;
            end
            MEM_WR: begin
               mem_addr_sel = 1'b1;
               mem_we       = mem_ready;
               instr_done   = mem_ready;
            end
            WB: begin
               case (instr)
                  OP_LW: begin
                     reg_dst = 2'd0;
                     wb_src  = 2'd1;
                  end
                  OP_ADD, OP_SUB, OP_SLT: reg_dst = 2'd1;
                  default: ;
               endcase
               reg_we     = ~ovfLatch;
               ovf_err    = ovfLatch;
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // State, overflow latch, sticky illegal flag and retired counter.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      if (reset) begin
         curState <= FETCH;
         ovfLatch <= 1'b0;
         illegal  <= 1'b0;
         retired  <= '0;
      end else begin
         if (instr_done)
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
         case (curState)
            FETCH: begin
               ovfLatch <= 1'b0;
               if (mem_ready)
                  curState <= DECODE;
            end
            DECODE: begin
               case (instr)
                  OP_J, OP_JAL, OP_JR: curState <= FETCH;
                  OP_BAD: begin
                     illegal  <= 1'b1;
                     curState <= HALT;
                  end
                  default: curState <= EXEC;
               endcase
            end
            EXEC: begin
               // Only signed-arithmetic ops can suppress their writeback.
               if (instr inside {OP_ADD, OP_SUB, OP_ADDI})
                  ovfLatch <= alu_overflow;
               case (instr)
                  OP_BEQ, OP_BNE: curState <= FETCH;
                  OP_LW:          curState <= MEM_RD;
                  OP_SW:          curState <= MEM_WR;
                  default:        curState <= WB;
               endcase
            end
            MEM_RD: if (mem_ready) curState <= WB;
            MEM_WR: if (mem_ready) curState <= FETCH;
            WB:     curState <= FETCH;
            HALT:   curState <= HALT;
            default: curState <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [5:0]       opcode, funct;
   logic             alu_zero, alu_overflow, mem_ready;
   logic             pc_we, ir_we, mem_addr_sel, mem_we, mem_re, reg_we;
   logic [1:0]       pc_src, reg_dst, wb_src, alu_src_b;
   logic [5:0]       alu_opcode, alu_funct;
   logic [2:0]       state;
   logic             instr_done, ovf_err, illegal;
   logic [CNT_W-1:0] retired;

   always #5 clk = ~clk;

   multicycle_control #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .alu_zero(alu_zero), .alu_overflow(alu_overflow), .mem_ready(mem_ready),
      .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_addr_sel(mem_addr_sel),
      .mem_we(mem_we), .mem_re(mem_re), .reg_we(reg_we), .reg_dst(reg_dst),
      .wb_src(wb_src), .alu_src_b(alu_src_b), .alu_opcode(alu_opcode),
      .alu_funct(alu_funct), .state(state), .instr_done(instr_done),
      .ovf_err(ovf_err), .illegal(illegal), .retired(retired)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum int {K_LW, K_SW, K_J, K_JAL, K_JR, K_BEQ, K_BNE, K_XORI, K_ADDI,
                     K_ADD, K_SUB, K_SLT, K_BAD} kindT;

   typedef struct packed {
      logic       pc_we;
      logic [1:0] pc_src;
      logic       ir_we, mem_addr_sel, mem_we, mem_re, reg_we;
      logic [1:0] reg_dst, wb_src, alu_src_b;
      logic [5:0] alu_opcode, alu_funct;
      logic       instr_done, ovf_err;
   } outsT;

   function automatic kindT classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h00: case (fn)
                   6'h08: return K_JR;
                   6'h20: return K_ADD;
                   6'h22: return K_SUB;
                   6'h2a: return K_SLT;
                   default: return K_BAD;
                endcase
         6'h23: return K_LW;
         6'h2b: return K_SW;
         6'h02: return K_J;
         6'h03: return K_JAL;
         6'h04: return K_BEQ;
         6'h05: return K_BNE;
         6'h0e: return K_XORI;
         6'h08: return K_ADDI;
         default: return K_BAD;
      endcase
   endfunction

   int m_state;
   bit m_ovf, m_illegal;
   int m_retired;
   bit run = 0;

   // Single compare process: at each falling edge the inputs are stable, so
   // the model predicts the combinational outputs and the next-edge update.
   initial begin
      outsT e;
      kindT k;
      int   nxt;
      bit   novf, nill;
      wait (run);
      forever begin
         @(negedge clk);
         e = '0;
         e.alu_opcode = 6'b001000;
         e.alu_funct  = 6'b100000;
         k    = classify(opcode, funct);
         nxt  = m_state;
         novf = m_ovf;
         nill = m_illegal;
         if (!reset) begin
            case (m_state)
               0: begin
                  e.mem_re = 1;
                  novf = 0;
                  if (mem_ready) begin e.ir_we = 1; e.pc_we = 1; nxt = 1; end
               end
               1: begin
                  if (k == K_J || k == K_JAL || k == K_JR) begin
                     e.pc_we = 1;
                     e.pc_src = (k == K_JR) ? 2'd3 : 2'd2;
                     e.instr_done = 1;
                     nxt = 0;
                     if (k == K_JAL) begin e.reg_we = 1; e.reg_dst = 2'd2; e.wb_src = 2'd2; end
                  end else if (k == K_BAD) begin
                     nill = 1; nxt = 7;
                  end else nxt = 2;
               end
               2: begin
                  if (k == K_LW || k == K_SW || k == K_ADDI) e.alu_src_b = 2'd1;
                  if (k == K_XORI) begin e.alu_opcode = 6'b001110; e.alu_src_b = 2'd2; end
                  if (k == K_ADD || k == K_SUB || k == K_SLT) begin
                     e.alu_opcode = 6'b000000; e.alu_funct = funct;
                  end
                  if (k == K_ADD || k == K_SUB || k == K_ADDI) novf = alu_overflow;
                  if (k == K_BEQ || k == K_BNE) begin
                     e.alu_opcode = opcode;
                     e.pc_we = (k == K_BEQ) ? alu_zero : !alu_zero;
                     e.pc_src = 2'd1;
                     e.instr_done = 1;
                     nxt = 0;
                  end else nxt = (k == K_LW) ? 3 : (k == K_SW) ? 4 : 5;
               end
               3: begin
                  e.mem_re = 1; e.mem_addr_sel = 1;
                  if (mem_ready) nxt = 5;
               end
               4: begin
                  e.mem_addr_sel = 1;
                  e.mem_we = mem_ready;
                  e.instr_done = mem_ready;
                  if (mem_ready) nxt = 0;
               end
               5: begin
                  if (k == K_LW) e.wb_src = 2'd1;
                  if (k == K_ADD || k == K_SUB || k == K_SLT) e.reg_dst = 2'd1;
                  e.reg_we = !m_ovf;
                  e.ovf_err = m_ovf;
                  e.instr_done = 1;
                  nxt = 0;
               end
               default: nxt = 7;
            endcase
         end
         check("state", 32'(state), m_state);
         check("illegal", 32'(illegal), 32'(m_illegal));
         check("retired", 32'(retired), m_retired);
         check("pc_we", 32'(pc_we), 32'(e.pc_we));
         check("pc_src", 32'(pc_src), 32'(e.pc_src));
         check("ir_we", 32'(ir_we), 32'(e.ir_we));
         check("mem_addr_sel", 32'(mem_addr_sel), 32'(e.mem_addr_sel));
         check("mem_we", 32'(mem_we), 32'(e.mem_we));
         check("mem_re", 32'(mem_re), 32'(e.mem_re));
         check("reg_we", 32'(reg_we), 32'(e.reg_we));
         check("reg_dst", 32'(reg_dst), 32'(e.reg_dst));
         check("wb_src", 32'(wb_src), 32'(e.wb_src));
         check("alu_src_b", 32'(alu_src_b), 32'(e.alu_src_b));
         check("alu_opcode", 32'(alu_opcode), 32'(e.alu_opcode));
         check("alu_funct", 32'(alu_funct), 32'(e.alu_funct));
         check("instr_done", 32'(instr_done), 32'(e.instr_done));
         check("ovf_err", 32'(ovf_err), 32'(e.ovf_err));
         if (reset) begin
            m_state = 0; m_ovf = 0; m_illegal = 0; m_retired = 0;
         end else begin
            m_retired = (m_retired + int'(e.instr_done)) % (1 << CNT_W);
            m_state = nxt; m_ovf = novf; m_illegal = nill;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic r, input logic rdy, input logic z, input logic ov);
      reset = r; mem_ready = rdy; alu_zero = z; alu_overflow = ov;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Begins an instruction: the core must be back in FETCH.
   task automatic startInstr(input logic [5:0] op, input logic [5:0] fn);
      opcode = op; funct = fn;
      cyc(0, 1, 0, 0);
      check("start in FETCH", 32'(state), 0);
      tick();
   endtask

   localparam logic [5:0] OPC_R = 6'h00, OPC_LW = 6'h23, OPC_SW = 6'h2b, OPC_J = 6'h02,
                          OPC_JAL = 6'h03, OPC_BEQ = 6'h04, OPC_BNE = 6'h05,
                          OPC_XORI = 6'h0e, OPC_ADDI = 6'h08;

   logic [5:0] opTab [12] = '{OPC_LW, OPC_SW, OPC_J, OPC_JAL, OPC_R, OPC_BEQ, OPC_BNE,
                              OPC_XORI, OPC_ADDI, OPC_R, OPC_R, OPC_R};
   logic [5:0] fnTab [12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00, 6'h00,
                              6'h00, 6'h00, 6'h20, 6'h22, 6'h2a};

   initial begin
      int haltCnt;
      reset = 1; opcode = 0; funct = 0; mem_ready = 0; alu_zero = 0; alu_overflow = 0;
      tick();
      m_state = 0; m_ovf = 0; m_illegal = 0; m_retired = 0;
      run = 1;
      tick();

      // 1: ADD walks FETCH, DECODE, EXEC, WB
      opcode = OPC_R; funct = 6'h20;
      cyc(0, 1, 0, 0); check("t1 fetch state", 32'(state), 0); check("t1 ir_we", 32'(ir_we), 1); tick();
      cyc(0, 1, 0, 0); check("t1 decode state", 32'(state), 1); tick();
      cyc(0, 1, 0, 0); check("t1 exec state", 32'(state), 2);
      check("t1 alu_opcode", 32'(alu_opcode), 0); check("t1 alu_funct", 32'(alu_funct), 32'h20); tick();
      cyc(0, 1, 0, 0); check("t1 wb state", 32'(state), 5); check("t1 reg_we", 32'(reg_we), 1);
      check("t1 reg_dst", 32'(reg_dst), 1); check("t1 wb_src", 32'(wb_src), 0); tick();
      cyc(0, 0, 0, 0); check("t1 retired", 32'(retired), 1); tick();

      // 2: LW with three memory wait cycles -> 8 cycles
      startInstr(OPC_LW, 6'h00);
      cyc(0, 1, 0, 0); tick();
      cyc(0, 1, 0, 0); check("t2 alu_opcode", 32'(alu_opcode), 32'h08); check("t2 alu_src_b", 32'(alu_src_b), 1); tick();
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0); check("t2 memrd wait", 32'(state), 3); tick();
      end
      cyc(0, 1, 0, 0); tick();
      cyc(0, 1, 0, 0); check("t2 wb reg_dst", 32'(reg_dst), 0); check("t2 wb wb_src", 32'(wb_src), 1);
      check("t2 wb done", 32'(instr_done), 1); tick();

      // 3: BEQ taken, BNE not taken
      startInstr(OPC_BEQ, 6'h00);
      cyc(0, 1, 0, 0); tick();
      cyc(0, 1, 1, 0); check("t3 beq pc_we", 32'(pc_we), 1); check("t3 beq pc_src", 32'(pc_src), 1); tick();
      startInstr(OPC_BNE, 6'h00);
      cyc(0, 1, 0, 0); tick();
      cyc(0, 1, 1, 0); check("t3 bne pc_we", 32'(pc_we), 0); check("t3 bne done", 32'(instr_done), 1); tick();

      // 4: ADDI overflow suppresses writeback, next ADDI writes
      startInstr(OPC_ADDI, 6'h00);
      cyc(0, 1, 0, 0); tick();
      cyc(0, 1, 0, 1); tick();
      cyc(0, 1, 0, 0); check("t4 ovf reg_we", 32'(reg_we), 0); check("t4 ovf_err", 32'(ovf_err), 1); tick();
      cyc(0, 0, 0, 0); check("t4 retired", 32'(retired), 5); tick();
      startInstr(OPC_ADDI, 6'h00);
      cyc(0, 1, 0, 0); tick();
      cyc(0, 1, 0, 0); tick();
      cyc(0, 1, 0, 0); check("t4 ok reg_we", 32'(reg_we), 1); check("t4 ok ovf_err", 32'(ovf_err), 0); tick();

      // 5: JAL, then illegal opcode halts
      startInstr(OPC_JAL, 6'h00);
      cyc(0, 1, 0, 0); check("t5 jal reg_we", 32'(reg_we), 1); check("t5 jal reg_dst", 32'(reg_dst), 2);
      check("t5 jal wb_src", 32'(wb_src), 2); check("t5 jal pc_src", 32'(pc_src), 2); tick();
      startInstr(6'h3f, 6'h00);
      cyc(0, 1, 0, 0); tick();
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, 1, 0); check("t5 halt state", 32'(state), 7); check("t5 halt pc_we", 32'(pc_we), 0);
         check("t5 illegal", 32'(illegal), 1); tick();
      end
      cyc(1, 1, 0, 0); tick();
      cyc(0, 0, 0, 0); check("t5 illegal cleared", 32'(illegal), 0); check("t5 retired cleared", 32'(retired), 0); tick();

      // 6: SW completes, then reset lands in MEM_WR
      startInstr(OPC_SW, 6'h00);
      cyc(0, 1, 0, 0); tick();
      cyc(0, 1, 0, 0); tick();
      cyc(0, 0, 0, 0); check("t6 memwr wait we", 32'(mem_we), 0); check("t6 memwr sel", 32'(mem_addr_sel), 1); tick();
      cyc(0, 1, 0, 0); check("t6 memwr we", 32'(mem_we), 1); tick();
      startInstr(OPC_SW, 6'h00);
      cyc(0, 1, 0, 0); tick();
      cyc(0, 1, 0, 0); tick();
      cyc(1, 1, 0, 0); tick();
      cyc(0, 0, 0, 0); check("t6 reset state", 32'(state), 0); check("t6 reset mem_we", 32'(mem_we), 0);
      check("t6 reset retired", 32'(retired), 0); tick();

      // Counter wrap at 2^CNT_W
      for (int i = 0; i < 15; i++) begin
         startInstr(OPC_J, 6'h00);
         cyc(0, 1, 0, 0); tick();
      end
      cyc(0, 0, 0, 0); check("wrap max", 32'(retired), 15); tick();
      startInstr(OPC_J, 6'h00);
      cyc(0, 1, 0, 0); tick();
      cyc(0, 0, 0, 0); check("wrap zero", 32'(retired), 0); tick();

      // Randomized traffic against the model
      haltCnt = 0;
      for (int n = 0; n < 3000; n++) begin
         logic r;
         if (m_state == 0) begin
            int idx;
            idx = $urandom_range(0, 13);
            if (idx < 12) begin
               opcode = opTab[idx];
               funct  = (opTab[idx] == OPC_R) ? fnTab[idx] : 6'($urandom);
            end else begin
               opcode = (idx == 12) ? 6'h00 : 6'($urandom);
               funct  = 6'($urandom);
            end
         end
         haltCnt = (m_state == 7) ? haltCnt + 1 : 0;
         r = (haltCnt >= 4) || ($urandom_range(0, 299) == 0);
         cyc(r, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
